// File: rtl/reset_seq_ctrl_if.sv
// Domain-side bundle of the reset sequencer: error/halt inputs,
// per-domain resets and run/halt status.
interface reset_seq_ctrl_if #(
   parameter int N_DOM = 3,
   parameter int CNT_W = 20
);
   logic [N_DOM-1:0] err;
   logic             halt_req;
   logic [N_DOM-1:0] dom_rst;
   logic             all_run;
   logic             halted;
   logic             err_flag;
   logic [N_DOM-1:0] err_src;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      input  err, halt_req,
      output dom_rst, all_run, halted,
      output err_flag, err_src, timeout,
      output cycle_count
   );

   modport slave (
      output err, halt_req,
      input  dom_rst, all_run, halted,
      input  err_flag, err_src, timeout,
      input  cycle_count
   );
endinterface

// File: rtl/reset_seq_ctrl.sv
// Staged reset release for N_DOM domains with error, watchdog
// and halt-request capture into sticky, registered status.
module reset_seq_ctrl #(
   parameter int N_DOM    = 3,
   parameter int HOLD_CYC = 2,
   parameter int GAP_CYC  = 4,
   parameter int TIMEOUT  = 1000000,
   parameter int CNT_W    = 20
) (
   input logic              clk,
   input logic              rst,
   reset_seq_ctrl_if.master bus
);

   localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
   localparam int MX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int GW = (MX > 1) ? $clog2(MX) : 1;

   localparam logic [GW-1:0]    HOLD_LAST = GW'(HOLD_CYC - 1);
   localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYC - 1);
   localparam logic [IW-1:0]    IDX_LAST  = IW'(N_DOM - 1);
   localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_RESET,
      S_HOLD,
      S_RELEASE,
      S_RUN,
      S_HALT
   } state_t;

   state_t           state;
   logic [GW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [N_DOM-1:0] dom_rst_q;
   logic             run_q;
   logic             halted_q;
   logic             err_q;
   logic [N_DOM-1:0] src_q;
   logic             to_q;
   logic [CNT_W-1:0] cyc_q;

   logic [N_DOM-1:0] hit;
   logic [CNT_W-1:0] cyc_nxt;

   // only domains already out of reset may raise an error
   assign hit     = bus.err & ~dom_rst_q;
   assign cyc_nxt = cyc_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_RESET;
         cnt       <= '0;
         idx       <= '0;
         dom_rst_q <= '1;
         run_q     <= 1'b0;
         halted_q  <= 1'b0;
         err_q     <= 1'b0;
         src_q     <= '0;
         to_q      <= 1'b0;
         cyc_q     <= '0;
      end else begin
         case (state)
            S_RESET: begin
               state <= S_HOLD;
               cnt   <= '0;
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  dom_rst_q[0] <= 1'b0;
                  cnt          <= '0;
                  idx          <= IW'(1);
                  if (N_DOM == 1) begin
                     state <= S_RUN;
                     run_q <= 1'b1;
                  end else begin
                     state <= S_RELEASE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (|hit) begin
                  err_q    <= 1'b1;
                  src_q    <= hit;
                  halted_q <= 1'b1;
                  state    <= S_HALT;
               end else if (cnt == GAP_LAST) begin
                  dom_rst_q[idx] <= 1'b0;
                  cnt            <= '0;
                  idx            <= idx + 1'b1;
                  if (idx == IDX_LAST) begin
                     state <= S_RUN;
                     run_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               // every cause seen on this edge is recorded together
               cyc_q <= cyc_nxt;
               if (cyc_nxt == TO_VAL) begin
                  to_q     <= 1'b1;
                  halted_q <= 1'b1;
                  state    <= S_HALT;
               end
               if (|hit) begin
                  err_q    <= 1'b1;
                  src_q    <= hit;
                  halted_q <= 1'b1;
                  state    <= S_HALT;
               end
               if (bus.halt_req) begin
                  halted_q <= 1'b1;
                  state    <= S_HALT;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_RESET;
            end
         endcase
      end
   end

   assign bus.dom_rst     = dom_rst_q;
   assign bus.all_run     = run_q;
   assign bus.halted      = halted_q;
   assign bus.err_flag    = err_q;
   assign bus.err_src     = src_q;
   assign bus.timeout     = to_q;
   assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: release timing, error masking,
// watchdog, halt request, coincident causes and mid-run reset.
module tb_reset_seq_ctrl;

   localparam int N = 3;
   localparam int W = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   reset_seq_ctrl_if #(.N_DOM(N), .CNT_W(W)) bus ();

   reset_seq_ctrl #(
      .N_DOM(N), .HOLD_CYC(2), .GAP_CYC(4),
      .TIMEOUT(20), .CNT_W(W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_dom"}, 32'(bus.dom_rst), 32'h7);
      chk({tag, "_run"}, 32'(bus.all_run), 32'h0);
      chk({tag, "_hlt"}, 32'(bus.halted), 32'h0);
      chk({tag, "_ef"},  32'(bus.err_flag), 32'h0);
      chk({tag, "_src"}, 32'(bus.err_src), 32'h0);
      chk({tag, "_to"},  32'(bus.timeout), 32'h0);
      chk({tag, "_cnt"}, 32'(bus.cycle_count), 32'h0);
   endtask

   // holds rst low for n edges, then releases so the next edge is E0
   task automatic do_reset(input int n);
      rst = 1'b0;
      step(n);
      rst = 1'b1;
   endtask

   initial begin
      bus.err      = '0;
      bus.halt_req = 1'b0;

      // release timing, masked error, then watchdog
      do_reset(3);
      chk_rst("rst0");
      step(1);
      chk("e0_dom", 32'(bus.dom_rst), 32'h7);
      step(1);
      chk("e1_dom", 32'(bus.dom_rst), 32'h7);
      step(1);
      chk("e2_dom", 32'(bus.dom_rst), 32'h6);
      bus.err = 3'b100;
      step(3);
      chk("e5_dom", 32'(bus.dom_rst), 32'h6);
      step(1);
      chk("e6_dom", 32'(bus.dom_rst), 32'h4);
      step(3);
      chk("e9_dom", 32'(bus.dom_rst), 32'h4);
      chk("e9_run", 32'(bus.all_run), 32'h0);
      chk("mask_hlt", 32'(bus.halted), 32'h0);
      chk("mask_ef", 32'(bus.err_flag), 32'h0);
      bus.err = '0;
      step(1);
      chk("e10_dom", 32'(bus.dom_rst), 32'h0);
      chk("e10_run", 32'(bus.all_run), 32'h1);
      chk("e10_cnt", 32'(bus.cycle_count), 32'd0);
      step(5);
      chk("e15_cnt", 32'(bus.cycle_count), 32'd5);
      step(14);
      chk("c19_cnt", 32'(bus.cycle_count), 32'd19);
      chk("c19_to", 32'(bus.timeout), 32'h0);
      step(1);
      chk("c20_cnt", 32'(bus.cycle_count), 32'd20);
      chk("c20_to", 32'(bus.timeout), 32'h1);
      chk("c20_hlt", 32'(bus.halted), 32'h1);
      chk("c20_ef", 32'(bus.err_flag), 32'h0);
      step(10);
      chk("frz_cnt", 32'(bus.cycle_count), 32'd20);
      chk("frz_run", 32'(bus.all_run), 32'h1);

      // error on a released domain during RELEASE
      do_reset(1);
      chk_rst("rst1");
      step(7);
      chk("r_e6_dom", 32'(bus.dom_rst), 32'h4);
      bus.err = 3'b010;
      step(1);
      chk("err_hlt", 32'(bus.halted), 32'h1);
      chk("err_ef", 32'(bus.err_flag), 32'h1);
      chk("err_src", 32'(bus.err_src), 32'h2);
      chk("err_dom", 32'(bus.dom_rst), 32'h4);
      chk("err_run", 32'(bus.all_run), 32'h0);
      chk("err_to", 32'(bus.timeout), 32'h0);
      bus.err = '0;
      step(4);
      chk("err_dom2", 32'(bus.dom_rst), 32'h4);
      chk("err_hlt2", 32'(bus.halted), 32'h1);

      // error and timeout on the same edge
      do_reset(1);
      step(11);
      chk("b_run", 32'(bus.all_run), 32'h1);
      step(19);
      chk("b_c19", 32'(bus.cycle_count), 32'd19);
      bus.err = 3'b001;
      step(1);
      bus.err = '0;
      chk("b_ef", 32'(bus.err_flag), 32'h1);
      chk("b_to", 32'(bus.timeout), 32'h1);
      chk("b_src", 32'(bus.err_src), 32'h1);
      chk("b_cnt", 32'(bus.cycle_count), 32'd20);
      chk("b_hlt", 32'(bus.halted), 32'h1);

      // halt request in RUN, later events ignored
      do_reset(1);
      step(11);
      step(7);
      chk("h_c7", 32'(bus.cycle_count), 32'd7);
      bus.halt_req = 1'b1;
      step(1);
      bus.halt_req = 1'b0;
      chk("h_hlt", 32'(bus.halted), 32'h1);
      chk("h_cnt", 32'(bus.cycle_count), 32'd8);
      chk("h_ef", 32'(bus.err_flag), 32'h0);
      chk("h_to", 32'(bus.timeout), 32'h0);
      bus.err = 3'b111;
      step(1);
      bus.err = '0;
      step(3);
      chk("h_src", 32'(bus.err_src), 32'h0);
      chk("h_ef2", 32'(bus.err_flag), 32'h0);
      chk("h_cnt2", 32'(bus.cycle_count), 32'd8);

      // reset mid-RELEASE, then a fresh sequence
      do_reset(1);
      step(8);
      chk("m_e7_dom", 32'(bus.dom_rst), 32'h4);
      rst = 1'b0;
      step(1);
      chk_rst("rst_mid");
      rst = 1'b1;
      step(2);
      chk("f_e1_dom", 32'(bus.dom_rst), 32'h7);
      bus.halt_req = 1'b1;
      step(1);
      chk("f_e2_dom", 32'(bus.dom_rst), 32'h6);
      step(1);
      bus.halt_req = 1'b0;
      chk("f_hreq_ign", 32'(bus.halted), 32'h0);
      step(3);
      chk("f_e6_dom", 32'(bus.dom_rst), 32'h4);
      step(4);
      chk("f_e10_dom", 32'(bus.dom_rst), 32'h0);
      chk("f_e10_run", 32'(bus.all_run), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
